// File: rtl/cacheline_burst_adaptor_pkg.sv
// rtl/cacheline_burst_adaptor_pkg.sv - shared types and helpers for the cache line burst adaptor
//
// Purpose : FSM state encoding and the line-address alignment helper used by
//           cacheline_burst_adaptor.
// Contents: adaptor_state_t  - IDLE / READ / WRITE / DONE
//           align_line_addr  - clears the low line-offset bits of an address
package cacheline_burst_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

    function automatic logic [31:0] align_line_addr(input logic [31:0] i_addr,
                                                    input int unsigned i_offset_bits);
        logic [31:0] w_mask;
        w_mask = ~((32'h1 << i_offset_bits) - 32'h1);
        return i_addr & w_mask;
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - converts single-cycle cache line requests into fixed-length memory bursts
//
// Purpose : Accepts one line read/write from the L2 physical-memory port and
//           runs a burst of width/burst_width beats against the memory model,
//           assembling (read) or serializing (write) the line in one shared
//           buffer, then pulses line_resp for one cycle.
// Ports   : clk, rst (async, active-low)
//           line_read, line_write, line_address, line_wdata  - L2 request (held until line_resp)
//           line_rdata, line_resp                            - L2 response
//           burst_read, burst_write, burst_address, burst_wdata - memory request
//           burst_rdata, burst_resp                          - memory per-beat reply
module cacheline_burst_adaptor
    import cacheline_burst_adaptor_pkg::*;
#(
    parameter int width       = 256,
    parameter int burst_width = 64,
    parameter int s_offset    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_read,
    input  logic                   line_write,
    input  logic [31:0]            line_address,
    input  logic [width-1:0]       line_wdata,
    output logic [width-1:0]       line_rdata,
    output logic                   line_resp,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [31:0]            burst_address,
    output logic [burst_width-1:0] burst_wdata,
    input  logic [burst_width-1:0] burst_rdata,
    input  logic                   burst_resp
);

    localparam int BEATS = width / burst_width;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    adaptor_state_t r_state;
    adaptor_state_t w_next_state;

    logic [CW-1:0]                         r_count;
    logic [31:0]                           r_addr;
    // One buffer serves both directions: filled from line_wdata for writes,
    // filled beat by beat from burst_rdata for reads.
    logic [BEATS-1:0][burst_width-1:0]     r_line;

    logic [31:0] w_aligned_addr;
    logic        w_last_beat;

    assign w_aligned_addr = align_line_addr(line_address, s_offset);
    assign w_last_beat    = (r_count == LAST_BEAT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        burst_read   = 1'b0;
        burst_write  = 1'b0;
        line_resp    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Write wins; a concurrent read stays asserted and is taken later.
                if (line_write) begin
                    w_next_state = WRITE;
                end else if (line_read) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                burst_read = 1'b1;
                if (burst_resp && w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            WRITE: begin
                burst_write = 1'b1;
                if (burst_resp && w_last_beat) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                line_resp    = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_line  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (line_write) begin
                        r_line  <= line_wdata;
                        r_addr  <= w_aligned_addr;
                        r_count <= '0;
                    end else if (line_read) begin
                        r_addr  <= w_aligned_addr;
                        r_count <= '0;
                    end
                end
                READ: begin
                    if (burst_resp) begin
                        r_line[r_count] <= burst_rdata;
                        r_count         <= r_count + 1'b1;
                    end
                end
                WRITE: begin
                    if (burst_resp) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign burst_address = r_addr;
    assign burst_wdata   = r_line[r_count];
    assign line_rdata    = r_line;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - self-checking bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;

    localparam int W     = 256;
    localparam int BW    = 64;
    localparam int BEATS = W / BW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          line_read = 1'b0;
    logic          line_write = 1'b0;
    logic [31:0]   line_address = '0;
    logic [W-1:0]  line_wdata = '0;
    logic [W-1:0]  line_rdata;
    logic          line_resp;
    logic          burst_read;
    logic          burst_write;
    logic [31:0]   burst_address;
    logic [BW-1:0] burst_wdata;
    logic [BW-1:0] burst_rdata = '0;
    logic          burst_resp = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cacheline_burst_adaptor #(
        .width(W), .burst_width(BW), .s_offset(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_address(burst_address),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Plays the memory side of one line transaction. Expected behaviour comes
    // from the protocol rules: burst request high from the cycle after
    // acceptance until the last beat is acknowledged, then one line_resp
    // cycle; latency = BEATS + 2 + stall cycles.
    task automatic run_txn(input bit do_wr, input bit keep_rd, input logic [31:0] addr,
                           input logic [W-1:0] data, input int stall_beat, input int stall_len,
                           input bit rnd_stall, input bit scramble, input string tag);
        int beat, stalls, det_stalls, cyc;
        bit done, stall, active, other;
        logic [31:0] exp_addr;
        logic [BW-1:0] exp_beat;
        beat = 0; stalls = 0; det_stalls = 0; cyc = 0; done = 0;
        exp_addr = {addr[31:5], 5'b0};
        line_address = addr;
        line_wdata   = do_wr ? data : rand_line();
        line_write   = do_wr;
        line_read    = !do_wr || keep_rd;
        burst_resp   = 1'b0;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            n_checks++;
            if (burst_read && burst_write) begin
                n_fail++; $display("FAIL %s excl: burst_read=%b burst_write=%b required not both", tag, burst_read, burst_write);
            end
            if (line_resp) begin
                n_checks++;
                if (beat !== BEATS) begin
                    n_fail++; $display("FAIL %s beats: got %0d required %0d", tag, beat, BEATS);
                end
                n_checks++;
                if (cyc + 1 !== BEATS + 2 + stalls) begin
                    n_fail++; $display("FAIL %s latency: got %0d required %0d", tag, cyc + 1, BEATS + 2 + stalls);
                end
                if (!do_wr) begin
                    n_checks++;
                    if (line_rdata !== data) begin
                        n_fail++; $display("FAIL %s rdata: got %h required %h", tag, line_rdata, data);
                    end
                end
                line_write = 1'b0;
                if (!(do_wr && keep_rd)) line_read = 1'b0;
                burst_resp = 1'b0;
                done = 1;
            end else begin
                active = do_wr ? burst_write : burst_read;
                other  = do_wr ? burst_read : burst_write;
                n_checks++;
                if (active !== (beat < BEATS) || other !== 1'b0) begin
                    n_fail++; $display("FAIL %s burst_req: got active=%b other=%b required active=%b other=0", tag, active, other, beat < BEATS);
                end
                if (active) begin
                    n_checks++;
                    if (burst_address !== exp_addr) begin
                        n_fail++; $display("FAIL %s burst_address: got %h required %h", tag, burst_address, exp_addr);
                    end
                    exp_beat = data[beat*BW +: BW];
                    if (do_wr) begin
                        n_checks++;
                        if (burst_wdata !== exp_beat) begin
                            n_fail++; $display("FAIL %s wdata beat %0d: got %h required %h", tag, beat, burst_wdata, exp_beat);
                        end
                    end
                    stall = 0;
                    if (beat == stall_beat && det_stalls < stall_len) begin
                        stall = 1; det_stalls++;
                    end else if (rnd_stall && $urandom_range(3) == 0) begin
                        stall = 1;
                    end
                    if (stall) begin
                        stalls++;
                        burst_resp  = 1'b0;
                        burst_rdata = {$urandom, $urandom};
                    end else begin
                        burst_resp  = 1'b1;
                        burst_rdata = exp_beat;
                        beat++;
                    end
                end else begin
                    burst_resp = 1'b0;
                end
                if (scramble) begin
                    line_address = $urandom;
                    line_wdata   = rand_line();
                end
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s timeout: got no line_resp within 60 cycles required one", tag);
        end
        burst_resp = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (line_resp || burst_read || burst_write) begin
            n_fail++; $display("FAIL %s after_done: got resp=%b rd=%b wr=%b required 0 0 0", tag, line_resp, burst_read, burst_write);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({line_resp, burst_read, burst_write} !== 3'b0 || burst_address !== 32'h0 ||
            burst_wdata !== '0 || line_rdata !== '0) begin
            n_fail++; $display("FAIL reset: got resp=%b rd=%b wr=%b addr=%h wdata=%h required all zero", line_resp, burst_read, burst_write, burst_address, burst_wdata);
        end
        rst = 1'b1;
        // Stray acknowledges while idle must be ignored.
        burst_resp = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if ({line_resp, burst_read, burst_write} !== 3'b0 || line_rdata !== '0) begin
                n_fail++; $display("FAIL idle_resp: got resp=%b rd=%b wr=%b required 0 0 0", line_resp, burst_read, burst_write);
            end
        end
        burst_resp = 1'b0;
    endtask

    task automatic test_read_basic();
        logic [W-1:0] d;
        d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_txn(0, 0, 32'h0000_1234, d, -1, 0, 0, 0, "read_basic");
    endtask

    task automatic test_write_basic();
        logic [W-1:0] d;
        d = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        run_txn(1, 0, 32'h8000_0040, d, -1, 0, 0, 0, "write_basic");
    endtask

    task automatic test_read_stall();
        run_txn(0, 0, 32'h0000_5A60, rand_line(), 2, 3, 0, 1, "read_stall");
    endtask

    task automatic test_write_read_collision();
        run_txn(1, 1, 32'h0000_0100, rand_line(), -1, 0, 0, 0, "collide_wr");
        run_txn(0, 0, 32'h0000_0100, rand_line(), -1, 0, 0, 0, "collide_rd");
    endtask

    task automatic test_reset_midburst();
        int beat;
        logic [W-1:0] d;
        d = rand_line();
        beat = 0;
        line_address = 32'h0000_0300;
        line_read    = 1'b1;
        @(posedge clk); #1;
        while (beat < 2) begin
            burst_resp  = 1'b1;
            burst_rdata = d[beat*BW +: BW];
            beat++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({line_resp, burst_read, burst_write} !== 3'b0 || burst_address !== 32'h0 ||
            burst_wdata !== '0 || line_rdata !== '0) begin
            n_fail++; $display("FAIL reset_mid: got resp=%b rd=%b wr=%b addr=%h rdata=%h required all zero", line_resp, burst_read, burst_write, burst_address, line_rdata);
        end
        line_read = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if (line_resp !== 1'b0) begin
                n_fail++; $display("FAIL reset_hold: got line_resp=%b required 0", line_resp);
            end
        end
        burst_resp = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(0, 0, 32'h0000_0200, rand_line(), -1, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn($urandom_range(1), 0, $urandom, rand_line(),
                    int'($urandom_range(BEATS)), int'($urandom_range(3)), 1, 1, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_txn(i[0], 0, 32'h1000_0000 + 32'(i * 32), rand_line(), -1, 0, 0, 0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_basic();
        test_read_stall();
        test_write_read_collision();
        test_reset_midburst();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
